wt_dcache_stride_pf: RTL and testbench

Parametrised stride prefetcher and the successor of the fixed single-stream prefetch unit on the wt_dcache load path. It observes granted demand loads and trains a table of NumStreams page-keyed stream entries. Once a constant stride reaches confidence, it queues up to Degree line-aligned prefetch addresses. It drains them to the miss unit over a req/gnt port.

---
 rtl/wt_dcache_stride_pf.sv | 244 ++++++++++++++++++++++++
 tb/tb_wt_dcache_stride_pf.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/wt_dcache_stride_pf.sv
// Stride prefetcher for the wt_dcache load path: page-keyed stream table, candidate generator
// and prefetch FIFO. Defining WT_DCACHE_PF_STATS_EN adds the issued/dropped statistics counters.
module wt_dcache_stride_pf #(
  parameter int unsigned PlenWidth  = 56,
  parameter int unsigned NumStreams = 4,
  parameter int unsigned Degree     = 2,
  parameter int unsigned ConfBits   = 2,
  parameter int unsigned ConfThresh = 2,
  parameter int unsigned QueueDepth = 4,
  parameter int unsigned LineOffW   = 6
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 enable_i,
  input  logic                 flush_i,
  input  logic                 obs_vld_i,
  input  logic [PlenWidth-1:0] obs_paddr_i,
  output logic                 pf_req_o,
  input  logic                 pf_gnt_i,
  output logic [PlenWidth-1:0] pf_paddr_o,
  output logic [31:0]          issued_cnt_o,
  output logic [31:0]          dropped_cnt_o
);

  localparam int unsigned PageW = PlenWidth - 12;
  localparam int unsigned SidxW = (NumStreams > 1) ? $clog2(NumStreams) : 1;
  localparam int unsigned QptrW = (QueueDepth > 1) ? $clog2(QueueDepth) : 1;
  localparam int unsigned QcntW = $clog2(QueueDepth + 1);
  localparam logic [ConfBits-1:0] ConfMax    = {ConfBits{1'b1}};
  localparam logic [ConfBits-1:0] ConfThr    = ConfBits'(ConfThresh);
  localparam logic [SidxW-1:0]    LastStream = SidxW'(NumStreams - 1);
  localparam logic [QptrW-1:0]    LastSlot   = QptrW'(QueueDepth - 1);
  localparam logic [QcntW-1:0]    QFull      = QcntW'(QueueDepth);
  localparam logic [3:0]          DegreeK    = 4'(Degree);

  typedef enum logic {IDLE = 1'b0, GEN = 1'b1} state_e;

  function automatic logic [PlenWidth-1:0] sext_stride(input logic signed [12:0] s);
    return {{(PlenWidth-13){s[12]}}, s};
  endfunction

  function automatic logic [PlenWidth-1:0] to_line(input logic [PlenWidth-1:0] a);
    return {a[PlenWidth-1:LineOffW], {LineOffW{1'b0}}};
  endfunction

  function automatic logic [QptrW-1:0] q_next(input logic [QptrW-1:0] p);
    return (p == LastSlot) ? '0 : p + 1'b1;
  endfunction

  logic [NumStreams-1:0] tbl_vld_q;
  logic [PageW-1:0]      tbl_page_q   [NumStreams];
  logic [11:0]           tbl_off_q    [NumStreams];
  logic signed [12:0]    tbl_stride_q [NumStreams];
  logic [ConfBits-1:0]   tbl_conf_q   [NumStreams];
  logic [SidxW-1:0]      rr_q;

  state_e                state_q;
  logic [3:0]            k_q;
  logic [PlenWidth-1:0]  cand_q, base_line_q, prev_line_q;
  logic signed [12:0]    gstride_q;

  logic [PlenWidth-1:0]  q_mem_q [QueueDepth];
  logic [QptrW-1:0]      q_wr_q, q_rd_q;
  logic [QcntW-1:0]      q_cnt_q;

  logic [PageW-1:0]      obs_page_s;
  logic [11:0]           obs_off_s, sel_off_s;
  logic                  hit_s, free_s, train_s, trig_s;
  logic [SidxW-1:0]      hit_idx_s, free_idx_s, alloc_idx_s;
  logic signed [12:0]    sel_stride_s, delta_s;
  logic [ConfBits-1:0]   sel_conf_s, conf_inc_s;
  logic [PlenWidth-1:0]  cand_line_s;
  logic                  gen_act_s, cand_ok_s, q_full_s, push_s, pop_s;

  assign obs_page_s = obs_paddr_i[PlenWidth-1:12];
  assign obs_off_s  = obs_paddr_i[11:0];

  // Lowest-index page match and lowest-index free entry
  always_comb begin
    hit_s      = 1'b0;
    hit_idx_s  = '0;
    free_s     = 1'b0;
    free_idx_s = '0;
    for (int i = NumStreams - 1; i >= 0; i--) begin
      hit_idx_s  = (tbl_vld_q[i] && (tbl_page_q[i] == obs_page_s)) ? SidxW'(i) : hit_idx_s;
      hit_s      = hit_s | (tbl_vld_q[i] & (tbl_page_q[i] == obs_page_s));
      free_idx_s = (!tbl_vld_q[i]) ? SidxW'(i) : free_idx_s;
      free_s     = free_s | ~tbl_vld_q[i];
    end
  end

  assign sel_off_s    = tbl_off_q[hit_idx_s];
  assign sel_stride_s = tbl_stride_q[hit_idx_s];
  assign sel_conf_s   = tbl_conf_q[hit_idx_s];
  assign delta_s      = $signed({1'b0, obs_off_s}) - $signed({1'b0, sel_off_s});
  assign conf_inc_s   = (sel_conf_s == ConfMax) ? sel_conf_s : sel_conf_s + ConfBits'(1);
  assign alloc_idx_s  = free_s ? free_idx_s : rr_q;
  assign train_s      = obs_vld_i & enable_i & ~flush_i;
  assign trig_s       = train_s & hit_s & (delta_s == sel_stride_s) & (sel_stride_s != 13'sd0)
                      & (conf_inc_s >= ConfThr) & (state_q == IDLE);

  // Stream table training and allocation
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      tbl_vld_q <= '0;
      rr_q      <= '0;
      for (int i = 0; i < NumStreams; i++) begin
        tbl_page_q[i]   <= '0;
        tbl_off_q[i]    <= 12'd0;
        tbl_stride_q[i] <= 13'sd0;
        tbl_conf_q[i]   <= '0;
      end
    end else if (flush_i) begin
      tbl_vld_q <= '0;
    end else if (train_s) begin
      if (hit_s) begin
        tbl_off_q[hit_idx_s] <= obs_off_s;
        if (delta_s == 13'sd0) begin
          tbl_conf_q[hit_idx_s] <= sel_conf_s;
        end else if (delta_s == sel_stride_s) begin
          tbl_conf_q[hit_idx_s] <= conf_inc_s;
        end else begin
          tbl_stride_q[hit_idx_s] <= delta_s;
          tbl_conf_q[hit_idx_s]   <= '0;
        end
      end else begin
        tbl_vld_q[alloc_idx_s]    <= 1'b1;
        tbl_page_q[alloc_idx_s]   <= obs_page_s;
        tbl_off_q[alloc_idx_s]    <= obs_off_s;
        tbl_stride_q[alloc_idx_s] <= 13'sd0;
        tbl_conf_q[alloc_idx_s]   <= '0;
        if (!free_s) begin
          rr_q <= (rr_q == LastStream) ? '0 : rr_q + 1'b1;
        end
      end
    end
  end

  // A candidate is kept only if it stays in the trigger page and names a new line
  assign cand_line_s = to_line(cand_q);
  assign gen_act_s   = (state_q == GEN) & enable_i & ~flush_i;
  assign cand_ok_s   = (cand_q[PlenWidth-1:12] == base_line_q[PlenWidth-1:12])
                     & (cand_line_s != base_line_q) & (cand_line_s != prev_line_q);
  assign q_full_s    = (q_cnt_q == QFull);
  assign push_s      = gen_act_s & cand_ok_s & ~q_full_s;

  // Candidate generator FSM
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q     <= IDLE;
      k_q         <= 4'd0;
      cand_q      <= '0;
      base_line_q <= '0;
      prev_line_q <= '0;
      gstride_q   <= 13'sd0;
    end else if (flush_i || !enable_i) begin
      state_q <= IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (trig_s) begin
            state_q     <= GEN;
            k_q         <= 4'd1;
            gstride_q   <= sel_stride_s;
            cand_q      <= obs_paddr_i + sext_stride(sel_stride_s);
            base_line_q <= to_line(obs_paddr_i);
            prev_line_q <= to_line(obs_paddr_i);
          end
        end
        GEN: begin
          cand_q      <= cand_q + sext_stride(gstride_q);
          prev_line_q <= cand_line_s;
          k_q         <= k_q + 4'd1;
          if (k_q == DegreeK) begin
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign pf_req_o   = (q_cnt_q != '0) & enable_i;
  assign pf_paddr_o = q_mem_q[q_rd_q];
  assign pop_s      = pf_req_o & pf_gnt_i;

  // Prefetch FIFO; fullness is judged before the same-cycle pop
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
      for (int i = 0; i < QueueDepth; i++) begin
        q_mem_q[i] <= '0;
      end
    end else if (flush_i || !enable_i) begin
      q_wr_q  <= '0;
      q_rd_q  <= '0;
      q_cnt_q <= '0;
    end else begin
      if (push_s) begin
        q_mem_q[q_wr_q] <= cand_line_s;
        q_wr_q          <= q_next(q_wr_q);
      end
      if (pop_s) begin
        q_rd_q <= q_next(q_rd_q);
      end
      case ({push_s, pop_s})
        2'b10:   q_cnt_q <= q_cnt_q + 1'b1;
        2'b01:   q_cnt_q <= q_cnt_q - 1'b1;
        default: q_cnt_q <= q_cnt_q;
      endcase
    end
  end

`ifdef WT_DCACHE_PF_STATS_EN
  logic [31:0] issued_q, dropped_q;
  logic        drop_s;

  assign drop_s = gen_act_s & cand_ok_s & q_full_s;

  // Wrapping statistics counters, untouched by flush
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      issued_q  <= 32'd0;
      dropped_q <= 32'd0;
    end else begin
      if (pop_s) begin
        issued_q <= issued_q + 32'd1;
      end
      if (drop_s) begin
        dropped_q <= dropped_q + 32'd1;
      end
    end
  end

  assign issued_cnt_o  = issued_q;
  assign dropped_cnt_o = dropped_q;
`else
  assign issued_cnt_o  = 32'd0;
  assign dropped_cnt_o = 32'd0;
`endif

endmodule

// File: tb/tb_wt_dcache_stride_pf.sv
// Self-checking bench for wt_dcache_stride_pf: directed scenarios plus random traffic against a
// reference model that expands each trigger into its whole candidate list up front.
module tb_wt_dcache_stride_pf;

  localparam int PW   = 56;
  localparam int NS   = 4;
  localparam int DEG  = 2;
  localparam int CB   = 2;
  localparam int CT   = 2;
  localparam int QD   = 4;
  localparam int LOW  = 6;
  localparam int CMAX = (1 << CB) - 1;
`ifdef WT_DCACHE_PF_STATS_EN
  localparam bit StatsEn = 1'b1;
`else
  localparam bit StatsEn = 1'b0;
`endif

  logic          clk_i = 1'b0;
  logic          rst_ni, enable_i, flush_i, obs_vld_i, pf_gnt_i, pf_req_o;
  logic [PW-1:0] obs_paddr_i, pf_paddr_o;
  logic [31:0]   issued_cnt_o, dropped_cnt_o;

  always #5 clk_i = ~clk_i;

  wt_dcache_stride_pf #(
    .PlenWidth(PW), .NumStreams(NS), .Degree(DEG), .ConfBits(CB),
    .ConfThresh(CT), .QueueDepth(QD), .LineOffW(LOW)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .enable_i(enable_i), .flush_i(flush_i),
    .obs_vld_i(obs_vld_i), .obs_paddr_i(obs_paddr_i), .pf_req_o(pf_req_o),
    .pf_gnt_i(pf_gnt_i), .pf_paddr_o(pf_paddr_o),
    .issued_cnt_o(issued_cnt_o), .dropped_cnt_o(dropped_cnt_o)
  );

  int total = 0;
  int bad   = 0;

  // reference model state
  bit          m_vld [NS];
  longint      m_page [NS];
  int          m_off [NS], m_stride [NS], m_conf [NS];
  int          m_rr;
  longint      m_fifo [$];
  longint      m_gen [$];
  logic [31:0] m_issued, m_dropped;
  longint      granted [$];
  int          rs_off [6], rs_stride [6], ss [6];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic longint gq(input int i);
    if (i < granted.size()) return granted[i];
    return -1;
  endfunction

  function automatic void m_reset();
    for (int i = 0; i < NS; i++) begin
      m_vld[i] = 1'b0; m_page[i] = 0; m_off[i] = 0; m_stride[i] = 0; m_conf[i] = 0;
    end
    m_rr = 0; m_issued = 32'd0; m_dropped = 32'd0;
    m_fifo.delete(); m_gen.delete();
  endfunction

  function automatic void m_train(input longint oa, input bit idle);
    longint pg, bl, prev, c, cl;
    int off, hit, slot, d, nc;
    pg = oa >>> 12; off = int'(oa & 64'hFFF); hit = -1; slot = -1;
    for (int i = NS - 1; i >= 0; i--) if (m_vld[i] && m_page[i] == pg) hit = i;
    if (hit >= 0) begin
      d = off - m_off[hit];
      if (d != 0 && d == m_stride[hit]) begin
        nc = (m_conf[hit] + 1 > CMAX) ? CMAX : m_conf[hit] + 1;
        m_conf[hit] = nc;
        if (idle && nc >= CT) begin
          // whole candidate list of this trigger; -1 marks a page/line drop
          bl = (oa >>> LOW) <<< LOW; prev = bl;
          for (int k = 1; k <= DEG; k++) begin
            c  = oa + longint'(k) * longint'(d);
            cl = (c >>> LOW) <<< LOW;
            m_gen.push_back(((c >>> 12) == pg && cl != bl && cl != prev) ? cl : -1);
            prev = cl;
          end
        end
      end else if (d != 0) begin
        m_stride[hit] = d; m_conf[hit] = 0;
      end
      m_off[hit] = off;
    end else begin
      for (int i = NS - 1; i >= 0; i--) if (!m_vld[i]) slot = i;
      if (slot < 0) begin
        slot = m_rr; m_rr = (m_rr + 1) % NS;
      end
      m_vld[slot] = 1'b1; m_page[slot] = pg; m_off[slot] = off;
      m_stride[slot] = 0; m_conf[slot] = 0;
    end
  endfunction

  function automatic void m_clock(input bit en, input bit fl, input bit ov, input longint oa, input bit gnt);
    bit req, idle, full;
    longint c;
    req  = (m_fifo.size() != 0) && en;
    idle = (m_gen.size() == 0);
    if (req && gnt) m_issued = m_issued + 32'd1;
    if (fl || !en) begin
      m_fifo.delete(); m_gen.delete();
      if (fl) for (int i = 0; i < NS; i++) m_vld[i] = 1'b0;
      return;
    end
    if (!idle) begin
      c    = m_gen.pop_front();
      full = (m_fifo.size() == QD);
      if (c >= 0) begin
        if (full) m_dropped = m_dropped + 32'd1;
        else m_fifo.push_back(c);
      end
    end
    if (req && gnt) void'(m_fifo.pop_front());
    if (ov) m_train(oa, idle);
  endfunction

  task automatic step(input bit en, input bit fl, input bit ov, input longint oa, input bit gnt);
    bit exp_req;
    enable_i = en; flush_i = fl; obs_vld_i = ov; pf_gnt_i = gnt;
    obs_paddr_i = ov ? PW'(oa) : '0;
    #1;
    exp_req = (m_fifo.size() != 0) && en;
    chk("req", 64'(pf_req_o), 64'(exp_req));
    if (exp_req) chk("paddr", 64'(pf_paddr_o), 64'(m_fifo[0]));
    chk("issued", 64'(issued_cnt_o), StatsEn ? 64'(m_issued) : 64'd0);
    chk("dropped", 64'(dropped_cnt_o), StatsEn ? 64'(m_dropped) : 64'd0);
    if (pf_req_o === 1'b1 && gnt) granted.push_back(longint'(pf_paddr_o));
    @(posedge clk_i);
    m_clock(en, fl, ov, oa, gnt);
    @(negedge clk_i);
  endtask

  task automatic loads(input longint a0, input longint stride, input int n, input bit gnt);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b1, a0 + longint'(i) * stride, gnt);
  endtask

  task automatic idle(input int n, input bit gnt);
    for (int i = 0; i < n; i++) step(1'b1, 1'b0, 1'b0, 0, gnt);
  endtask

  initial begin
    int cur;
    bit en, fl, ov, gnt;
    longint oa;
    rst_ni = 1'b0; enable_i = 1'b1; flush_i = 1'b0; obs_vld_i = 1'b0;
    obs_paddr_i = '0; pf_gnt_i = 1'b0;
    ss[0] = 64; ss[1] = -64; ss[2] = 128; ss[3] = 8; ss[4] = 256; ss[5] = -192;
    for (int i = 0; i < 6; i++) begin
      rs_off[i] = i * 320; rs_stride[i] = ss[i];
    end
    m_reset();
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    rst_ni = 1'b1;
    #1;
    chk("rst_req", 64'(pf_req_o), 64'd0);
    chk("rst_paddr", 64'(pf_paddr_o), 64'd0);
    chk("rst_issued", 64'(issued_cnt_o), 64'd0);
    chk("rst_dropped", 64'(dropped_cnt_o), 64'd0);

    // basic +0x40 stream
    granted.delete();
    loads(64'h1000, 64'h40, 4, 1'b1);
    idle(6, 1'b1);
    chk("s1_n", 64'(granted.size()), 64'd2);
    chk("s1_a0", 64'(gq(0)), 64'h1100);
    chk("s1_a1", 64'(gq(1)), 64'h1140);
    chk("s1_empty", 64'(pf_req_o), 64'd0);

    // page-crossing candidate is dropped
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    granted.delete();
    loads(64'h1E80, 64'h40, 4, 1'b1);
    idle(2, 1'b1);
    loads(64'h1F80, 64'h40, 1, 1'b1);
    idle(6, 1'b1);
    chk("s2_n", 64'(granted.size()), 64'd3);
    chk("s2_a0", 64'(gq(0)), 64'h1F80);
    chk("s2_a1", 64'(gq(1)), 64'h1FC0);
    chk("s2_a2", 64'(gq(2)), 64'h1FC0);

    // negative stride
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    granted.delete();
    loads(64'h5300, -64'sh40, 4, 1'b1);
    idle(6, 1'b1);
    chk("s3_n", 64'(granted.size()), 64'd2);
    chk("s3_a0", 64'(gq(0)), 64'h5200);
    chk("s3_a1", 64'(gq(1)), 64'h51C0);

    // sub-line stride: every candidate falls in the base line
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    granted.delete();
    loads(64'h3000, 64'h8, 4, 1'b1);
    idle(6, 1'b1);
    chk("s4_n", 64'(granted.size()), 64'd0);

    // three streams with no grant overflow the queue
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    granted.delete();
    loads(64'h6000, 64'h40, 4, 1'b0); idle(2, 1'b0);
    loads(64'h7000, 64'h40, 4, 1'b0); idle(2, 1'b0);
    loads(64'h8000, 64'h40, 4, 1'b0); idle(3, 1'b0);
    chk("s5_head", 64'(pf_paddr_o), 64'h6100);
    chk("s5_dropped", 64'(dropped_cnt_o), StatsEn ? 64'd2 : 64'd0);
    idle(6, 1'b1);
    chk("s5_n", 64'(granted.size()), 64'd4);
    chk("s5_a0", 64'(gq(0)), 64'h6100);
    chk("s5_a3", 64'(gq(3)), 64'h7140);

    // flush during GEN with two entries already queued
    step(1'b1, 1'b1, 1'b0, 0, 1'b1);
    loads(64'h9000, 64'h40, 4, 1'b0); idle(2, 1'b0);
    loads(64'h1000, 64'h40, 4, 1'b0);
    step(1'b1, 1'b1, 1'b0, 0, 1'b0);
    #1;
    chk("s6_req_after_flush", 64'(pf_req_o), 64'd0);
    loads(64'h10C0, 64'h40, 1, 1'b0);
    idle(4, 1'b0);
    chk("s6_no_trigger", 64'(pf_req_o), 64'd0);

    // random traffic, several streams than table entries, random enable/flush/grant
    cur = 0;
    for (int n = 0; n < 2000; n++) begin
      en  = ($urandom_range(0, 24) != 0);
      fl  = ($urandom_range(0, 79) == 0);
      ov  = ($urandom_range(0, 3) != 0);
      gnt = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 3) == 0) cur = int'($urandom_range(0, 5));
      if ($urandom_range(0, 11) == 0) rs_stride[cur] = ss[$urandom_range(0, 5)];
      if ($urandom_range(0, 29) == 0) rs_off[cur] = int'($urandom_range(0, 4095));
      else rs_off[cur] = (rs_off[cur] + rs_stride[cur]) & 32'hFFF;
      oa = (longint'(64 + cur) <<< 12) | longint'(rs_off[cur]);
      step(en, fl, ov, oa, gnt);
    end
    idle(8, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
